// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, tracks reads in flight to a synchronous ROM
// and buffers returned words with their PCs in a credit-checked FIFO feeding decode.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 15,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ROM_LATENCY = 1,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ROM_LATENCY-1:0] infl_vld_q, infl_vld_d;
    logic [ADDR_WIDTH-1:0]  infl_pc_q [ROM_LATENCY];
    logic [ADDR_WIDTH-1:0]  infl_pc_d [ROM_LATENCY];
    logic [DATA_WIDTH-1:0]  fifo_inst_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_inst_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [CNT_W-1:0]       infl_cnt;
    logic [CNT_W-1:0]       occupancy;
    logic                   pop;
    logic                   issue;
    logic                   push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign rom_addr   = pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;

    // Credit: every read in flight already owns a FIFO slot, so a return can never overflow.
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            infl_cnt = infl_cnt + CNT_W'(infl_vld_q[i]);
        end
        pop       = inst_valid && inst_ready;
        occupancy = count_q + infl_cnt - CNT_W'(pop);
        issue     = fetch_en && !redirect_valid && (occupancy < CNT_W'(FIFO_DEPTH));
        push      = infl_vld_q[ROM_LATENCY-1] && !redirect_valid;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end

        infl_vld_d    = '0;
        infl_pc_d     = infl_pc_q;
        infl_vld_d[0] = issue;
        infl_pc_d[0]  = pc_q;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            infl_vld_d[i] = infl_vld_q[i-1];
            infl_pc_d[i]  = infl_pc_q[i-1];
        end
        if (redirect_valid) begin
            infl_vld_d = '0;
        end
    end

    // A pop on a redirect edge is still consumed by decode; its slot simply vanishes in the flush.
    always_comb begin
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_inst_d[wr_ptr_q] = rom_data;
                fifo_pc_d[wr_ptr_q]   = infl_pc_q[ROM_LATENCY-1];
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            infl_vld_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            infl_vld_q <= infl_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage is qualified by the valid bits and count, so it needs no reset.
    always_ff @(posedge clk) begin
        infl_pc_q   <= infl_pc_d;
        fifo_inst_q <= fifo_inst_d;
        fifo_pc_q   <= fifo_pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (ROM latency 1 and 3) against a timestamped queue model,
// a start-up vector table, directed corner sequences and a randomized run.
module tb_fetch_unit;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RST_PC = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_ready;

    logic [AW-1:0] a1, a3, p1, p3;
    logic [DW-1:0] d1, d3, i1, i3;
    logic          v1, v3;
    logic [DW-1:0] rom3_s [3];

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1), .FIFO_DEPTH(DEPTH),
                 .RESET_PC(RST_PC)) u_l1 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .rom_addr(a1), .rom_data(d1), .inst_valid(v1),
        .inst(i1), .inst_pc(p1), .inst_ready(inst_ready));

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3), .FIFO_DEPTH(DEPTH),
                 .RESET_PC(RST_PC)) u_l3 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .rom_addr(a3), .rom_data(d3), .inst_valid(v3),
        .inst(i3), .inst_pc(p3), .inst_ready(inst_ready));

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + {17'd0, a};
    endfunction

    always @(posedge clk) d1 <= rom_word(a1);
    always @(posedge clk) begin
        rom3_s[0] <= rom_word(a3);
        rom3_s[1] <= rom3_s[0];
        rom3_s[2] <= rom3_s[1];
    end
    assign d3 = rom3_s[2];

    int total = 0;
    int bad   = 0;
    int unsigned edge_n = 0;

    // Reference model per instance: issued reads carry the edge at which they must land.
    logic [AW-1:0] m_pc  [2];
    int            m_fn  [2];
    int            m_in  [2];
    logic [AW-1:0] m_fpc [2][8];
    logic [AW-1:0] m_ipc [2][8];
    int unsigned   m_due [2][8];
    logic [AW-1:0] mon_next [2];

    typedef struct {
        logic          rst_i;
        logic          fen;
        logic          rdy;
        logic          e1_v;
        logic [AW-1:0] e1_pc;
        logic [AW-1:0] e_addr;
        logic          e3_v;
        logic [AW-1:0] e3_pc;
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t mk(input logic r, input logic e1v, input int e1pc, input int ea,
                                input logic e3v, input int e3pc);
        vec_t v;
        v.rst_i  = r;
        v.fen    = 1'b1;
        v.rdy    = 1'b1;
        v.e1_v   = e1v;
        v.e1_pc  = AW'(e1pc);
        v.e_addr = AW'(ea);
        v.e3_v   = e3v;
        v.e3_pc  = AW'(e3pc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int lat = (k == 0) ? 1 : 3;
        int fn;
        int inn;
        bit pop;
        bit iss;
        if (rst !== 1'b1) begin
            m_pc[k] = RST_PC;
            m_fn[k] = 0;
            m_in[k] = 0;
            return;
        end
        fn  = m_fn[k];
        inn = m_in[k];
        pop = (fn > 0) && inst_ready;
        if (redirect_valid) begin
            m_pc[k] = redirect_pc;
            m_fn[k] = 0;
            m_in[k] = 0;
            return;
        end
        iss = fetch_en && (fn + inn - (pop ? 1 : 0) < DEPTH);
        if (pop) begin
            for (int j = 0; j < m_fn[k] - 1; j++) m_fpc[k][j] = m_fpc[k][j+1];
            m_fn[k]--;
        end
        if (m_in[k] > 0 && m_due[k][0] == edge_n) begin
            m_fpc[k][m_fn[k]] = m_ipc[k][0];
            m_fn[k]++;
            for (int j = 0; j < m_in[k] - 1; j++) begin
                m_ipc[k][j] = m_ipc[k][j+1];
                m_due[k][j] = m_due[k][j+1];
            end
            m_in[k]--;
        end
        if (iss) begin
            m_ipc[k][m_in[k]] = m_pc[k];
            m_due[k][m_in[k]] = edge_n + lat;
            m_in[k]++;
            m_pc[k] = m_pc[k] + AW'(1);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic          ov;
            logic [DW-1:0] oi;
            logic [AW-1:0] op, oa;
            logic          ev;
            string         tag;
            tag = (k == 0) ? "L1" : "L3";
            ov  = (k == 0) ? v1 : v3;
            oi  = (k == 0) ? i1 : i3;
            op  = (k == 0) ? p1 : p3;
            oa  = (k == 0) ? a1 : a3;
            ev  = (m_fn[k] > 0);
            chk({tag, "_valid"}, 32'(ov), 32'(ev));
            chk({tag, "_inst"}, oi, ev ? rom_word(m_fpc[k][0]) : 32'd0);
            chk({tag, "_inst_pc"}, 32'(op), ev ? 32'(m_fpc[k][0]) : 32'd0);
            chk({tag, "_rom_addr"}, 32'(oa), 32'(m_pc[k]));
        end
    endtask

    // Delivered PCs must be consecutive from the last reset/redirect target.
    task automatic monitor(input int k);
        logic          ov;
        logic [AW-1:0] op;
        ov = (k == 0) ? v1 : v3;
        op = (k == 0) ? p1 : p3;
        if (rst === 1'b1 && ov === 1'b1 && inst_ready) begin
            chk((k == 0) ? "L1_order" : "L3_order", 32'(op), 32'(mon_next[k]));
            mon_next[k] = op + AW'(1);
        end
        if (rst !== 1'b1) mon_next[k] = RST_PC;
        else if (redirect_valid) mon_next[k] = redirect_pc;
    endtask

    task automatic step();
        monitor(0);
        monitor(1);
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        check_model();
    endtask

    task automatic run_table();
        for (int r = 0; r < 7; r++) begin
            rst        = tbl[r].rst_i;
            fetch_en   = tbl[r].fen;
            inst_ready = tbl[r].rdy;
            redirect_valid = 1'b0;
            step();
            chk("tbl_v1", 32'(v1), 32'(tbl[r].e1_v));
            chk("tbl_p1", 32'(p1), tbl[r].e1_v ? 32'(tbl[r].e1_pc) : 32'd0);
            chk("tbl_i1", i1, tbl[r].e1_v ? rom_word(tbl[r].e1_pc) : 32'd0);
            chk("tbl_a1", 32'(a1), 32'(tbl[r].e_addr));
            chk("tbl_v3", 32'(v3), 32'(tbl[r].e3_v));
            chk("tbl_p3", 32'(p3), tbl[r].e3_v ? 32'(tbl[r].e3_pc) : 32'd0);
            chk("tbl_a3", 32'(a3), 32'(tbl[r].e_addr));
        end
    endtask

    initial begin
        rst = 1'b0;
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;

        tbl[0] = mk(1'b0, 1'b0, 0, 0, 1'b0, 0);
        tbl[1] = mk(1'b0, 1'b0, 0, 0, 1'b0, 0);
        tbl[2] = mk(1'b0, 1'b0, 0, 0, 1'b0, 0);
        tbl[3] = mk(1'b1, 1'b0, 0, 1, 1'b0, 0);
        tbl[4] = mk(1'b1, 1'b1, 0, 2, 1'b0, 0);
        tbl[5] = mk(1'b1, 1'b1, 1, 3, 1'b0, 0);
        tbl[6] = mk(1'b1, 1'b1, 2, 4, 1'b1, 0);

        run_table();

        // Backpressure with PC 2 at the L1 head.
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_v1", 32'(v1), 32'd1);
            chk("bp_hold_p1", 32'(p1), 32'd2);
            chk("bp_hold_p3", 32'(p3), 32'd0);
        end
        chk("bp_sat_a1", 32'(a1), 32'd6);
        chk("bp_sat_a3", 32'(a3), 32'd4);
        inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();

        // Redirect while the L1 FIFO holds three entries.
        redirect_valid = 1'b1;
        redirect_pc    = 15'h0100;
        step();
        chk("rd_v1_R", 32'(v1), 32'd0);
        chk("rd_v3_R", 32'(v3), 32'd0);
        redirect_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rd_v1", 32'(v1), (i >= 2) ? 32'd1 : 32'd0);
            if (i == 2) chk("rd_p1", 32'(p1), 32'h0100);
            chk("rd_v3", 32'(v3), (i >= 4) ? 32'd1 : 32'd0);
            if (i == 4) chk("rd_p3", 32'(p3), 32'h0100);
        end
        for (int i = 0; i < 4; i++) step();

        // PC wrap, then fetch disable.
        redirect_valid = 1'b1;
        redirect_pc    = 15'h7FFE;
        step();
        redirect_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 2) chk("wrap_p1_a", 32'(p1), 32'h7FFE);
            if (i == 3) chk("wrap_p1_b", 32'(p1), 32'h7FFF);
            if (i == 4) chk("wrap_p1_c", 32'(p1), 32'h0000);
        end
        fetch_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("drain_v1", 32'(v1), 32'd0);
        chk("drain_v3", 32'(v3), 32'd0);
        chk("drain_a1", 32'(a1), 32'h0006);
        chk("drain_a3", 32'(a3), 32'h0006);

        // Reset with the FIFO full and reads in flight, then a clean restart.
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b0;
        step();
        chk("mrst_v1", 32'(v1), 32'd0);
        chk("mrst_a1", 32'(a1), 32'(RST_PC));
        chk("mrst_v3", 32'(v3), 32'd0);
        chk("mrst_a3", 32'(a3), 32'(RST_PC));
        run_table();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 199) != 0);
            fetch_en       = ($urandom_range(0, 7) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? AW'(15'h7FFC + AW'($urandom_range(0, 3)))
                                                         : AW'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage. Owns the program counter, issues word addresses to a synchronous instruction ROM of configurable read latency, tracks in-flight reads, and buffers returned instructions in a small FIFO. The FIFO presents each instruction with its PC to decode over a valid/ready handshake. Supports branch/jump redirect with flush of all stale fetches and backpressure from decode without losing or duplicating instructions.

## Interface
- ADDR_WIDTH, 15: PC / ROM word-address width.
- DATA_WIDTH, 32: instruction width.
- ROM_LATENCY, 1: number of clk edges between the ROM sampling rom_addr and rom_data being captured; legal range 1..4.
- FIFO_DEPTH, 4: output buffer entries; must be >= ROM_LATENCY+1.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_en  in  1  1 = issue new fetches; 0 = stop issuing, in-flight reads still complete.
- redirect_valid  in  1  load redirect_pc and flush for one cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- rom_addr  out  ADDR_WIDTH  equals the current PC register, combinationally.
- rom_data  in  DATA_WIDTH  ROM read data, ROM_LATENCY edges after address sample.
- inst_valid  out  1  FIFO head valid.
- inst  out  DATA_WIDTH  head instruction; 0 when inst_valid=0.
- inst_pc  out  ADDR_WIDTH  PC of head instruction; 0 when inst_valid=0.
- inst_ready  in  1  decode accepts head this cycle.

## Operation
- State: pc_q; in-flight shift register of ROM_LATENCY stages (valid bit + PC each); FIFO of FIFO_DEPTH entries (instruction + PC) with count.
- Reset (rst=0 at an edge): pc_q=RESET_PC, all in-flight valid bits cleared, FIFO emptied. inst_valid=0, inst=0, inst_pc=0. Reset overrides all other inputs.
- pop = inst_valid & inst_ready.
- Issue: at an edge, issue = fetch_en & ~redirect_valid & (fifo_count + inflight_count - pop < FIFO_DEPTH). On issue, stage 0 captures {1, pc_q} and pc_q <= pc_q + 1 modulo 2^ADDR_WIDTH (0x7FFF -> 0x0000 at default width). Otherwise stage 0 captures valid=0 and pc_q holds.
- Return: when the last in-flight stage is valid, rom_data and that stage's PC are written to the FIFO tail at the same edge. Credit rule guarantees the FIFO never overflows; the write is never dropped.
- Push and pop may happen at the same edge; count is unchanged and ordering is preserved.
- Redirect (redirect_valid=1 at an edge, rst=1): pc_q <= redirect_pc; all in-flight valid bits cleared; FIFO emptied. No issue occurs at that edge. A pop at the same edge counts as completed for decode but is discarded with the flush. A return arriving at that edge is dropped.
- fetch_en=0: no issue. In-flight reads land in the FIFO. The PC holds.

## Timing
- First edge with rst=1 (E0) issues RESET_PC. inst_valid rises after edge E0+ROM_LATENCY.
- Redirect at edge R: redirect_pc is issued at R+1, and inst_valid with inst_pc=redirect_pc rises after R+1+ROM_LATENCY. inst_valid=0 from R until then.
- Steady state with inst_ready=1 and fetch_en=1: one instruction per cycle, consecutive PCs, no bubbles.
- inst_ready=0: inst, inst_pc and inst_valid hold stable. Issue stops once occupancy reaches FIFO_DEPTH. When ready returns, delivery resumes at 1/cycle with no gap while the FIFO is non-empty.
- Outputs are driven from registered FIFO state. There is no combinational path from inst_ready to inst_valid.

## Test plan
- Reset/start-up: ROM word n = 0xA000_0000+n, ROM_LATENCY=1, hold rst=0 for 3 cycles then release with inst_ready=1 -> inst_valid=0 during reset; first valid shows inst=0xA000_0000, inst_pc=0, one cycle after E0; then PCs 1,2,3... every cycle.
- Backpressure: drop inst_ready for 10 cycles after PC 2 is presented -> PC 2 is held stable; occupancy saturates at 4 with no ROM issue beyond credit; after release, PCs 2,3,4,5,... are delivered contiguously with no loss or duplicates.
- Redirect: assert redirect_valid with redirect_pc=0x0100 while the FIFO holds 3 entries -> inst_valid=0 next cycle; the next delivered entry is inst_pc=0x0100 after 1+ROM_LATENCY edges; no stale PC is ever delivered.
- Latency sweep: ROM_LATENCY=3, FIFO_DEPTH=4, inst_ready=1 -> first valid 3 edges after E0; sustained 1 instruction/cycle.
- Wrap and fetch_en: redirect to 0x7FFE -> delivery sequence 0x7FFE, 0x7FFF, 0x0000. Then deassert fetch_en -> in-flight entries drain, then inst_valid=0 and rom_addr stays constant.
- Reset mid-operation: rst=0 with the FIFO full and reads in flight -> the next cycle shows inst_valid=0 and rom_addr=RESET_PC; after release, restart occurs exactly as in the start-up scenario.
